i2s_tx: RTL and testbench

Stereo I2S transmitter that sits after `audio_equalizer` on the playback path. It accepts parallel 24-bit processed samples, one left/right pair at a time, through a valid/ready handshake. It generates the I2S bit clock and word clock from `sample_clock` and serialises each pair MSB-first to an external DAC.

---
 rtl/eq_audio_pkg.sv | 13 +
 rtl/i2s_clkgen.sv | 48 ++++
 rtl/i2s_tx.sv | 118 +++++++++++
 tb/tb_i2s_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_audio_pkg.sv
// Shared audio-path constants and types for the equalizer playback chain.
// Used by the I2S transmitter and the I2S receiver that feeds audio_equalizer.
package eq_audio_pkg;

    localparam int SAMPLE_WD  = 24;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int OFF_W      = $clog2(SLOT_BITS);

    typedef logic signed [SAMPLE_WD-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator: BCLK divider, falling-edge strobe,
// frame bit position and LRCLK.
module i2s_clkgen
    import eq_audio_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic             sample_clock,
    input  logic             reset,
    output logic             bclk_o,
    output logic             lrclk_o,
    output logic             fall_o,
    output logic [POS_W-1:0] pos_o
);

    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == CNT_W'(BCLK_DIV - 1));
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d    = wrap ? ~bclk_q : bclk_q;
        fall_o    = wrap & bclk_q;
        pos_d     = fall_o ? pos_q + 1'b1 : pos_q;
    end

    // pos resets to the last slot bit so the first fall starts a new frame
    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            pos_q     <= '1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            pos_q     <= pos_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = pos_q[POS_W-1];
    assign pos_o   = pos_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: valid/ready pair intake, one-entry hold
// register, and MSB-first serialiser with one-bit I2S delay.
module i2s_tx
    import eq_audio_pkg::*;
#(
    parameter int WD       = SAMPLE_WD,
    parameter int BCLK_DIV = 16
) (
    input  logic          sample_clock,
    input  logic          reset,
    input  logic [WD-1:0] in_left,
    input  logic [WD-1:0] in_right,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          i2s_bclk,
    output logic          i2s_lrclk,
    output logic          i2s_sdata,
    output logic          frame_start,
    output logic          underrun
);

    logic             fall;
    logic [POS_W-1:0] pos;

    logic             hold_full_q, hold_full_d;
    logic [WD-1:0]    hold_l_q, hold_l_d;
    logic [WD-1:0]    hold_r_q, hold_r_d;
    logic [WD-1:0]    l_q, l_d;
    logic [WD-1:0]    r_q, r_d;
    logic             sdata_q, sdata_d;
    logic             fs_q, fs_d;
    logic             und_q, und_d;

    logic             load;
    logic [POS_W-1:0] pos_nx;
    logic [OFF_W-1:0] off;
    logic [WD-1:0]    word;
    logic [WD-1:0]    shifted;

    i2s_clkgen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_clkgen (
        .sample_clock(sample_clock),
        .reset       (reset),
        .bclk_o      (i2s_bclk),
        .lrclk_o     (i2s_lrclk),
        .fall_o      (fall),
        .pos_o       (pos)
    );

    assign in_ready = !hold_full_q;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        l_d         = l_q;
        r_d         = r_q;
        load        = fall && (pos == '1);
        fs_d        = load;
        und_d       = load && !hold_full_q && !in_valid;

        if (load) begin
            hold_full_d = 1'b0;
            if (hold_full_q) begin
                l_d = hold_l_q;
                r_d = hold_r_q;
            end else if (in_valid) begin
                l_d = in_left;
                r_d = in_right;
            end else begin
                l_d = '0;
                r_d = '0;
            end
        end else if (in_valid && in_ready) begin
            hold_full_d = 1'b1;
            hold_l_d    = in_left;
            hold_r_d    = in_right;
        end

        // slot offset 1..WD carries sample bit WD-offset; position 0 is the delay bit
        pos_nx  = pos + 1'b1;
        off     = pos_nx[OFF_W-1:0];
        word    = pos_nx[POS_W-1] ? r_q : l_q;
        shifted = word >> (OFF_W'(WD) - off);
        sdata_d = sdata_q;
        if (fall) begin
            sdata_d = (off != '0) && (off <= OFF_W'(WD)) && shifted[0];
        end
    end

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            l_q         <= '0;
            r_q         <= '0;
            sdata_q     <= 1'b0;
            fs_q        <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            l_q         <= l_d;
            r_q         <= r_d;
            sdata_q     <= sdata_d;
            fs_q        <= fs_d;
            und_q       <= und_d;
        end
    end

    assign i2s_sdata   = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = und_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx with BCLK_DIV=2 (256-clock frames).
// A monitor decodes serial frames; tasks push expected frames and compare.
module tb_i2s_tx;

    localparam int WD  = 24;
    localparam int DIV = 2;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        uf;
        logic        pad_ok;
        logic        lr_ok;
        int          cyc;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WD-1:0] in_left = '0;
    logic [WD-1:0] in_right = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, bclk, lrclk, sdata, fs, und;

    int checks = 0;
    int errors = 0;
    int cyc;

    frame_t got_q[$];
    frame_t exp_q[$];

    always #5 clk = ~clk;

    i2s_tx #(.WD(WD), .BCLK_DIV(DIV)) dut (
        .sample_clock(clk),
        .reset       (rst_n),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .i2s_bclk    (bclk),
        .i2s_lrclk   (lrclk),
        .i2s_sdata   (sdata),
        .frame_start (fs),
        .underrun    (und)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int          mk = -1;
    logic [63:0] mbits, mlr;
    logic        muf;
    int          mcyc;
    logic        bprev = 1'b0;

    always @(posedge clk) begin
        frame_t f;
        #1;
        if (!rst_n) begin
            mk = -1;
        end else if (fs) begin
            mk = 0;
            muf = und;
            mcyc = cyc;
        end else if (bclk && !bprev && mk >= 0) begin
            mbits = {mbits[62:0], sdata};
            mlr   = {mlr[62:0], lrclk};
            mk++;
            if (mk == 64) begin
                f.l      = mbits[62:39];
                f.r      = mbits[30:7];
                f.uf     = muf;
                f.pad_ok = !mbits[63] && (mbits[38:31] == 8'h0) && (mbits[6:0] == 7'h0);
                f.lr_ok  = (mlr == 64'h0000_0000_FFFF_FFFF);
                f.cyc    = mcyc;
                got_q.push_back(f);
                mk = -1;
            end
        end
        bprev = bclk;
    end

    function automatic frame_t mkf(input logic [23:0] l, input logic [23:0] r, input logic uf);
        frame_t f;
        f.l = l; f.r = r; f.uf = uf;
        f.pad_ok = 1'b1; f.lr_ok = 1'b1; f.cyc = 0;
        return f;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, output int acc);
        int   n = 0;
        logic rdy;
        in_left = l; in_right = r; in_valid = 1'b1;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 2000);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL handshake: in_ready=0 after %0d cycles, want 1", n);
        end else begin
            exp_q.push_back(mkf(l, r, 1'b0));
        end
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int rise = -1, fall = -1, fsc = -1, unc = -1;
        logic lr_fall = 1'bx;
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        if (bclk !== 1'b0)     begin errors++; $display("FAIL rst_bclk: got %b want 0", bclk); end
        if (lrclk !== 1'b1)    begin errors++; $display("FAIL rst_lrclk: got %b want 1", lrclk); end
        if (sdata !== 1'b0)    begin errors++; $display("FAIL rst_sdata: got %b want 0", sdata); end
        if (fs !== 1'b0)       begin errors++; $display("FAIL rst_fs: got %b want 0", fs); end
        if (und !== 1'b0)      begin errors++; $display("FAIL rst_und: got %b want 0", und); end
        got_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bclk && rise < 0) rise = c;
            if (!bclk && rise >= 0 && fall < 0) begin fall = c; lr_fall = lrclk; end
            if (fs && fsc < 0) fsc = c;
            if (und && unc < 0) unc = c;
        end
        checks += 5;
        if (rise != 2)        begin errors++; $display("FAIL first_rise: got %0d want 2", rise); end
        if (fall != 4)        begin errors++; $display("FAIL first_fall: got %0d want 4", fall); end
        if (fsc != 4)         begin errors++; $display("FAIL first_fs: got %0d want 4", fsc); end
        if (unc != 4)         begin errors++; $display("FAIL first_und: got %0d want 4", unc); end
        if (lr_fall !== 1'b0) begin errors++; $display("FAIL lrclk_fall: got %b want 0", lr_fall); end
    endtask

    task automatic test_single_pair();
        int acc, n = 0, i = 0;
        frame_t g, e;
        do_reset();
        send_pair(24'h800001, 24'h7FFFFE, acc);
        in_valid = 1'b0;
        exp_q.push_back(mkf(24'h0, 24'h0, 1'b1));
        checks++;
        if (acc != 1) begin errors++; $display("FAIL single_acc: got %0d want 1", acc); end
        while (got_q.size() < 2 && n < 1000) begin @(posedge clk); n++; end
        checks++;
        if (got_q.size() < 2) begin errors++; $display("FAIL single_frames: got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g.l !== e.l || g.r !== e.r || g.uf !== e.uf || !g.pad_ok || !g.lr_ok || g.cyc != 4 + 256 * i) begin
                errors++;
                $display("FAIL single_frame%0d: got L=%h R=%h uf=%b pad=%b lr=%b cyc=%0d want L=%h R=%h uf=%b pad=1 lr=1 cyc=%0d",
                         i, g.l, g.r, g.uf, g.pad_ok, g.lr_ok, g.cyc, e.l, e.r, e.uf, 4 + 256 * i);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        int acc[8];
        int n = 0, i = 0;
        frame_t g, e;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send_pair(24'($urandom), 24'($urandom), acc[k]);
        end
        in_valid = 1'b0;
        checks += 2;
        if (acc[0] != 1) begin errors++; $display("FAIL b2b_acc0: got %0d want 1", acc[0]); end
        if (acc[1] != 5) begin errors++; $display("FAIL b2b_acc1: got %0d want 5", acc[1]); end
        for (int k = 2; k < 8; k++) begin
            checks++;
            if (acc[k] - acc[k-1] != 256) begin
                errors++;
                $display("FAIL b2b_gap%0d: got %0d want 256", k, acc[k] - acc[k-1]);
            end
        end
        while (got_q.size() < 8 && n < 3000) begin @(posedge clk); n++; end
        checks++;
        if (got_q.size() < 8) begin errors++; $display("FAIL b2b_frames: got %0d want 8", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0 && i < 8) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g.l !== e.l || g.r !== e.r || g.uf !== e.uf || !g.pad_ok || !g.lr_ok || g.cyc != 4 + 256 * i) begin
                errors++;
                $display("FAIL b2b_frame%0d: got L=%h R=%h uf=%b pad=%b lr=%b cyc=%0d want L=%h R=%h uf=%b pad=1 lr=1 cyc=%0d",
                         i, g.l, g.r, g.uf, g.pad_ok, g.lr_ok, g.cyc, e.l, e.r, e.uf, 4 + 256 * i);
            end
            i++;
        end
    endtask

    task automatic test_bypass();
        int acc, n = 0, i = 0;
        frame_t g, e;
        do_reset();
        exp_q.push_back(mkf(24'h0, 24'h0, 1'b1));
        while (cyc < 259 && n < 400) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        send_pair(24'h123456, 24'hABCDEF, acc);
        in_valid = 1'b0;
        checks += 3;
        if (acc != 260) begin errors++; $display("FAIL bypass_acc: got %0d want 260", acc); end
        if (dut.hold_full_q !== 1'b0) begin errors++; $display("FAIL bypass_hold: got %b want 0", dut.hold_full_q); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b want 1", in_ready); end
        n = 0;
        while (got_q.size() < 2 && n < 1000) begin @(posedge clk); n++; end
        checks++;
        if (got_q.size() < 2) begin errors++; $display("FAIL bypass_frames: got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g.l !== e.l || g.r !== e.r || g.uf !== e.uf || !g.pad_ok || !g.lr_ok || g.cyc != 4 + 256 * i) begin
                errors++;
                $display("FAIL bypass_frame%0d: got L=%h R=%h uf=%b pad=%b lr=%b cyc=%0d want L=%h R=%h uf=%b pad=1 lr=1 cyc=%0d",
                         i, g.l, g.r, g.uf, g.pad_ok, g.lr_ok, g.cyc, e.l, e.r, e.uf, 4 + 256 * i);
            end
            i++;
        end
    endtask

    task automatic test_underrun();
        int n = 0, i = 0;
        frame_t g, e;
        in_valid = 1'b0;
        do_reset();
        exp_q.push_back(mkf(24'h0, 24'h0, 1'b1));
        exp_q.push_back(mkf(24'h0, 24'h0, 1'b1));
        while (got_q.size() < 2 && n < 1000) begin @(posedge clk); n++; end
        checks++;
        if (got_q.size() < 2) begin errors++; $display("FAIL under_frames: got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g.l !== e.l || g.r !== e.r || g.uf !== e.uf || !g.pad_ok || !g.lr_ok || g.cyc != 4 + 256 * i) begin
                errors++;
                $display("FAIL under_frame%0d: got L=%h R=%h uf=%b pad=%b lr=%b cyc=%0d want L=%h R=%h uf=%b pad=1 lr=1 cyc=%0d",
                         i, g.l, g.r, g.uf, g.pad_ok, g.lr_ok, g.cyc, e.l, e.r, e.uf, 4 + 256 * i);
            end
            i++;
        end
    endtask

    task automatic test_mid_reset();
        int acc, n = 0;
        do_reset();
        send_pair(24'h111111, 24'h222222, acc);
        send_pair(24'h333333, 24'h444444, acc);
        in_valid = 1'b0;
        while (cyc < 46 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pre: got %b want 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        if (bclk !== 1'b0)     begin errors++; $display("FAIL mid_bclk: got %b want 0", bclk); end
        if (lrclk !== 1'b1)    begin errors++; $display("FAIL mid_lrclk: got %b want 1", lrclk); end
        if (sdata !== 1'b0)    begin errors++; $display("FAIL mid_sdata: got %b want 0", sdata); end
        if (fs !== 1'b0)       begin errors++; $display("FAIL mid_fs: got %b want 0", fs); end
        if (und !== 1'b0)      begin errors++; $display("FAIL mid_und: got %b want 0", und); end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_bypass();
        test_underrun();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
